// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared defaults for the generic pipeline stage register:
//               bundle widths, counter width and skid-mode encodings.
//               The entry record (valid, ctrl, data) is built per instance
//               inside pipe_stage_reg from these widths.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Default bundle widths used by the core's stage boundaries.
    localparam int PIPE_CTRL_W = 16;
    localparam int PIPE_DATA_W = 128;
    localparam int PIPE_CNT_W  = 16;

    // Skid-mode selection values for the SKID parameter.
    localparam int SKID_NONE = 0;   // single entry, combinational ready
    localparam int SKID_TWO  = 1;   // main + skid entry, registered ready

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : pipe_sat_counter
// Description : Saturating up-counter. Increments by one on each cycle with
//               inc=1 and sticks at all-ones instead of wrapping.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset (count -> 0)
//               inc   - increment request
//               count - current count value
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_sat_counter
    import pipe_pkg::*;
#(
    parameter int CNT_W = PIPE_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = &r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && !w_at_max) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule : pipe_sat_counter
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Generic elastic pipeline stage register with valid/ready
//               handshake, optional two-entry skid buffer (registered
//               upstream ready), control-only flush and saturating stall /
//               flush performance counters.
// Ports       : clk, rst_n          - clock / async active-low reset
//               flush               - kill all held and incoming entries
//               in_valid/in_ready   - upstream handshake
//               in_ctrl/in_data     - upstream control / data bundles
//               out_valid/out_ready - downstream handshake
//               out_ctrl/out_data   - downstream bundles (ctrl=0 when idle)
//               stall_cnt           - cycles stalled by downstream
//               flush_cnt           - flushes that killed a valid entry
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int DATA_W = PIPE_DATA_W,
    parameter int SKID   = SKID_NONE,
    parameter int CNT_W  = PIPE_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t r_main;         // entry presented downstream
    entry_t w_in_entry;     // incoming entry as it would be captured
    logic   w_any_valid;    // some held entry is valid (flush accounting)
    logic   w_stall_inc;
    logic   w_flush_inc;

    assign w_in_entry = '{valid: 1'b1, ctrl: in_ctrl, data: in_data};

    generate
        if (SKID == SKID_NONE) begin : g_skid_none
            // Ready looks through to downstream so a full entry can be
            // replaced in the same cycle it is delivered.
            assign in_ready    = ~r_main.valid | out_ready;
            assign w_any_valid = r_main.valid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_main <= '0;
                end else if (flush) begin
                    // Data is left in place; only the control bundle dies.
                    r_main.valid <= 1'b0;
                    r_main.ctrl  <= '0;
                end else if (in_ready) begin
                    if (in_valid) begin
                        r_main <= w_in_entry;
                    end else begin
                        r_main.valid <= 1'b0;
                        r_main.ctrl  <= '0;
                    end
                end
            end
        end else begin : g_skid_two
            entry_t r_skid;
            logic   w_in_xfer;
            logic   w_main_free;

            // Ready depends only on a flop: the skid slot is the reserve
            // that absorbs the one entry accepted after downstream stalls.
            assign in_ready    = ~r_skid.valid;
            assign w_in_xfer   = in_valid & ~r_skid.valid;
            assign w_main_free = ~r_main.valid | out_ready;
            assign w_any_valid = r_main.valid | r_skid.valid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_main <= '0;
                    r_skid <= '0;
                end else if (flush) begin
                    r_main.valid <= 1'b0;
                    r_main.ctrl  <= '0;
                    r_skid.valid <= 1'b0;
                    r_skid.ctrl  <= '0;
                end else if (w_main_free) begin
                    if (r_skid.valid) begin
                        // Skid refills main. in_ready is low whenever skid is
                        // occupied, so no input can arrive alongside this move.
                        r_main       <= r_skid;
                        r_skid.valid <= 1'b0;
                        r_skid.ctrl  <= '0;
                    end else if (w_in_xfer) begin
                        r_main <= w_in_entry;
                    end else begin
                        r_main.valid <= 1'b0;
                        r_main.ctrl  <= '0;
                    end
                end else if (w_in_xfer) begin
                    r_skid <= w_in_entry;
                end
            end
        end
    endgenerate

    assign out_valid = r_main.valid;
    assign out_ctrl  = r_main.ctrl;
    assign out_data  = r_main.data;

    assign w_stall_inc = r_main.valid & ~out_ready & ~flush;
    assign w_flush_inc = flush & w_any_valid;

    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_stall_inc),
        .count (stall_cnt)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_flush_inc),
        .count (flush_cnt)
    );

endmodule : pipe_stage_reg
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Self-checking bench for pipe_stage_reg. Instance 0 is
//               SKID=0 with a 4-bit counter (saturation), instance 1 is
//               SKID=1 with a 16-bit counter. A per-instance scoreboard
//               queues every accepted entry and checks each delivered one;
//               directed checks cover reset, latency, backpressure, flush
//               and counter values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int CW = 16;
    localparam int DW = 32;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush     [2];
    logic          in_valid  [2];
    logic          in_ready  [2];
    logic [CW-1:0] in_ctrl   [2];
    logic [DW-1:0] in_data   [2];
    logic          out_valid [2];
    logic          out_ready [2];
    logic [CW-1:0] out_ctrl  [2];
    logic [DW-1:0] out_data  [2];
    logic [3:0]    stall0, flush0;
    logic [15:0]   stall1, flush1;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_ctrl(in_ctrl[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_ctrl(out_ctrl[0]), .out_data(out_data[0]),
        .stall_cnt(stall0), .flush_cnt(flush0)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_ctrl(in_ctrl[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_ctrl(out_ctrl[1]), .out_data(out_data[1]),
        .stall_cnt(stall1), .flush_cnt(flush1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic v, input logic [CW-1:0] c, input logic [DW-1:0] x);
        in_valid[d] = v;
        in_ctrl[d]  = c;
        in_data[d]  = x;
    endtask

    // Scoreboard: push on accepted input, pop on delivered output.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        exp_t q[$];
        exp_t e;
        always @(negedge clk) begin
            if (!rst_n) begin
                q.delete();
            end else begin
                if (out_valid[g] && out_ready[g]) begin
                    if (q.size() == 0) begin
                        chk($sformatf("sb%0d_unexpected_out", g), out_data[g], 32'hxxxx_xxxx);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("sb%0d_data", g), out_data[g], e.d);
                        chk($sformatf("sb%0d_ctrl", g), {16'h0, out_ctrl[g]}, {16'h0, e.c});
                    end
                end
                if (!out_valid[g])
                    chk($sformatf("sb%0d_idle_ctrl", g), {16'h0, out_ctrl[g]}, 32'h0);
                if (flush[g])
                    q.delete();
                else if (in_valid[g] && in_ready[g])
                    q.push_back('{c: in_ctrl[g], d: in_data[g]});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            flush[d] = 1'b0; out_ready[d] = 1'b0;
            drive(d, 1'b0, '0, '0);
        end

        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_in_ready0", {31'h0, in_ready[0]}, 32'h1);
        chk("rst_in_ready1", {31'h0, in_ready[1]}, 32'h1);
        chk("rst_out_valid1", {31'h0, out_valid[1]}, 32'h0);
        chk("rst_out_data1", out_data[1], 32'h0);
        #3 rst_n = 1'b1;
        tick();
        chk("rst_stall0", {28'h0, stall0}, 32'h0);
        chk("rst_flush1", {16'h0, flush1}, 32'h0);

        // ---------------- streaming 1..8, both modes ----------------
        for (int d = 0; d < 2; d++) begin
            out_ready[d] = 1'b1;
            for (int i = 1; i <= 8; i++) begin
                drive(d, 1'b1, CW'(16'h0100 + i), DW'(i));
                chk($sformatf("stream%0d_in_ready", d), {31'h0, in_ready[d]}, 32'h1);
                tick();
                chk($sformatf("stream%0d_valid", d), {31'h0, out_valid[d]}, 32'h1);
                chk($sformatf("stream%0d_data", d), out_data[d], i);
            end
            drive(d, 1'b0, '0, '0);
            tick();
            chk($sformatf("stream%0d_drained", d), {31'h0, out_valid[d]}, 32'h0);
        end
        chk("stream_stall0", {28'h0, stall0}, 32'h0);
        chk("stream_stall1", {16'h0, stall1}, 32'h0);

        // ---------------- backpressure, SKID=1 ----------------
        out_ready[1] = 1'b0;
        drive(1, 1'b1, 16'h000A, 32'hA0);
        tick();
        chk("bp_A_held", out_data[1], 32'hA0);
        chk("bp_ready_after_A", {31'h0, in_ready[1]}, 32'h1);
        drive(1, 1'b1, 16'h000B, 32'hB0);
        tick();
        chk("bp_ready_after_B", {31'h0, in_ready[1]}, 32'h0);
        chk("bp_A_still", out_data[1], 32'hA0);
        drive(1, 1'b1, 16'h000C, 32'hC0);
        tick();
        chk("bp_C_blocked", {31'h0, in_ready[1]}, 32'h0);
        chk("bp_A_ctrl", {16'h0, out_ctrl[1]}, 32'hA);
        chk("bp_stall", {16'h0, stall1}, 32'h2);
        out_ready[1] = 1'b1;
        tick();
        chk("bp_B_out", out_data[1], 32'hB0);
        tick();
        chk("bp_C_out", out_data[1], 32'hC0);
        drive(1, 1'b0, '0, '0);
        tick();
        chk("bp_empty", {31'h0, out_valid[1]}, 32'h0);
        chk("bp_stall_final", {16'h0, stall1}, 32'h2);

        // ---------------- flush with skid full, SKID=1 ----------------
        out_ready[1] = 1'b0;
        drive(1, 1'b1, 16'h0011, 32'hD1);
        tick();
        drive(1, 1'b1, 16'h0022, 32'hD2);
        tick();
        drive(1, 1'b1, 16'h0033, 32'hD3);
        flush[1] = 1'b1;
        tick();
        flush[1] = 1'b0;
        drive(1, 1'b0, '0, '0);
        chk("fl_out_valid", {31'h0, out_valid[1]}, 32'h0);
        chk("fl_out_ctrl", {16'h0, out_ctrl[1]}, 32'h0);
        chk("fl_data_kept", out_data[1], 32'hD1);
        chk("fl_in_ready", {31'h0, in_ready[1]}, 32'h1);
        chk("fl_cnt", {16'h0, flush1}, 32'h1);
        chk("fl_stall", {16'h0, stall1}, 32'h3);
        out_ready[1] = 1'b1;
        tick(); tick();
        chk("fl_C_gone", {31'h0, out_valid[1]}, 32'h0);

        // ---------------- flush while empty ----------------
        flush[1] = 1'b1;
        tick();
        flush[1] = 1'b0;
        chk("fle_cnt1", {16'h0, flush1}, 32'h1);
        drive(0, 1'b1, 16'h0077, 32'h77);
        flush[0] = 1'b1;
        tick();
        flush[0] = 1'b0;
        drive(0, 1'b0, '0, '0);
        chk("fle_drop_valid0", {31'h0, out_valid[0]}, 32'h0);
        chk("fle_ready0", {31'h0, in_ready[0]}, 32'h1);
        chk("fle_cnt0", {28'h0, flush0}, 32'h0);

        // ---------------- stall counter saturation, CNT_W=4 ----------------
        out_ready[0] = 1'b0;
        drive(0, 1'b1, 16'h0005, 32'h5A);
        tick();
        drive(0, 1'b0, '0, '0);
        for (int i = 0; i < 20; i++) tick();
        chk("sat_stall0", {28'h0, stall0}, 32'hF);
        tick();
        chk("sat_stall0_hold", {28'h0, stall0}, 32'hF);
        chk("sat_data_stable", out_data[0], 32'h5A);
        out_ready[0] = 1'b1;
        tick();

        // ---------------- asynchronous reset mid-stream ----------------
        for (int d = 0; d < 2; d++) begin
            out_ready[d] = 1'b0;
            drive(d, 1'b1, 16'hFFFF, 32'h55);
        end
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid0", {31'h0, out_valid[0]}, 32'h0);
        chk("arst_valid1", {31'h0, out_valid[1]}, 32'h0);
        chk("arst_ctrl1", {16'h0, out_ctrl[1]}, 32'h0);
        chk("arst_stall0", {28'h0, stall0}, 32'h0);
        chk("arst_stall1", {16'h0, stall1}, 32'h0);
        chk("arst_flush1", {16'h0, flush1}, 32'h0);
        chk("arst_ready1", {31'h0, in_ready[1]}, 32'h1);
        for (int d = 0; d < 2; d++) drive(d, 1'b0, '0, '0);
        tick();
        #3 rst_n = 1'b1;
        tick();
        chk("post_rst_ready0", {31'h0, in_ready[0]}, 32'h1);
        chk("post_rst_ready1", {31'h0, in_ready[1]}, 32'h1);
        chk("post_rst_valid1", {31'h0, out_valid[1]}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_pipe_stage_reg
`default_nettype wire
